// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny CPU: opcodes, PC width, loader states.
// Instruction format is {opcode[2:0], operand[4:0]}.
package tiny_cpu_pkg;

    localparam int PC_W = 5;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDI = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_BEQ = 3'd6;
    localparam logic [2:0] OP_BNE = 3'd7;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_ARM   = 2'd1,
        LD_SHIFT = 2'd2,
        LD_WRITE = 2'd3
    } loader_state_t;

    function automatic logic [7:0] instr(
        input logic [2:0]      op,
        input logic [PC_W-1:0] arg
    );
        return {op, arg};
    endfunction

endpackage

// File: rtl/tiny_cpu_sync_edge.sv
// Pin synchronizer (STAGES flops) plus one history flop for edge pulses.
// Ports: clk, reset_n, d (async pin), q (synced level), rise/fall (1-clk pulses).
module tiny_cpu_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/tiny_cpu_prog_loader.sv
// Serially loaded 32x8 program RAM with ROM-style combinational fetch port.
// Ports: serial pins (ser_clk/ser_dat/load_en), fetch_addr->fetch_data, status outputs.
module tiny_cpu_prog_loader
    import tiny_cpu_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int AW          = PC_W,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ser_clk,
    input  logic          ser_dat,
    input  logic          load_en,
    input  logic [AW-1:0] fetch_addr,
    output logic [DW-1:0] fetch_data,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          overflow,
    output logic [AW:0]   byte_count
);

    localparam int BW = $clog2(DW) + 1;

    logic sc_s, sc_rise, sc_fall;
    logic sd_s, sd_rise, sd_fall;
    logic ld_s, ld_rise, ld_fall;

    tiny_cpu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sc (
        .clk(clk), .reset_n(reset_n), .d(ser_clk),
        .q(sc_s), .rise(sc_rise), .fall(sc_fall)
    );

    tiny_cpu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk(clk), .reset_n(reset_n), .d(ser_dat),
        .q(sd_s), .rise(sd_rise), .fall(sd_fall)
    );

    tiny_cpu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ld (
        .clk(clk), .reset_n(reset_n), .d(load_en),
        .q(ld_s), .rise(ld_rise), .fall(ld_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sc_s, sc_fall, sd_rise, sd_fall, ld_fall};

    loader_state_t   state;
    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   shreg;
    logic [BW-1:0]   bit_cnt;

    assign fetch_data = mem[fetch_addr];

    // The session end is taken from the synced level rather than the fall
    // pulse, so a fall that lands during WRITE is still honoured one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LD_IDLE;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            unique case (state)
                LD_IDLE: begin
                    if (ld_rise) begin
                        state      <= LD_ARM;
                        cpu_hold   <= 1'b1;
                        byte_count <= '0;
                        bit_cnt    <= '0;
                        overflow   <= 1'b0;
                        load_done  <= 1'b0;
                    end
                end
                LD_ARM: begin
                    if (!ld_s) begin
                        state     <= LD_IDLE;
                        cpu_hold  <= 1'b0;
                        load_done <= (byte_count != '0);
                    end else begin
                        state <= LD_SHIFT;
                    end
                end
                LD_SHIFT: begin
                    if (!ld_s) begin
                        state     <= LD_IDLE;
                        cpu_hold  <= 1'b0;
                        bit_cnt   <= '0;
                        load_done <= (byte_count != '0);
                    end else if (sc_rise) begin
                        shreg   <= {shreg[DW-2:0], sd_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DW - 1)) state <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    if (byte_count < (AW+1)'(DEPTH)) begin
                        mem[byte_count[AW-1:0]] <= shreg;
                        byte_count <= byte_count + 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                    bit_cnt <= '0;
                    state   <= LD_SHIFT;
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_cpu_prog_loader.sv
// Bench for tiny_cpu_prog_loader: serial loads, scoreboarded fetch checks.
// Covers partial byte, overflow, mid-load reset, idle ser_clk, program load.
module tb_tiny_cpu_prog_loader;
    import tiny_cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ser_clk = 1'b0;
    logic       ser_dat = 1'b0;
    logic       load_en = 1'b0;
    logic [4:0] fetch_addr = '0;
    logic [7:0] fetch_data;
    logic       cpu_hold, load_done, overflow;
    logic [5:0] byte_count;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    logic exp_ovf = 1'b0;

    always #5 clk = ~clk;

    tiny_cpu_prog_loader dut (
        .clk(clk), .reset_n(reset_n),
        .ser_clk(ser_clk), .ser_dat(ser_dat), .load_en(load_en),
        .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .cpu_hold(cpu_hold), .load_done(load_done),
        .overflow(overflow), .byte_count(byte_count)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ser_clk = 1'b0;
        ser_dat = b;
        repeat (5) @(negedge clk);
        ser_clk = 1'b1;
        repeat (5) @(negedge clk);
        ser_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        vec_t e;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        if (exp_cnt < 32) begin
            e.addr = 5'(exp_cnt);
            e.data = v;
            sb.push_back(e);
            exp_cnt++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic start_session();
        @(negedge clk);
        load_en = 1'b1;
        exp_cnt = 0;
        exp_ovf = 1'b0;
        repeat (6) @(negedge clk);
        check("hold_in_session", 32'(cpu_hold), 32'd1);
    endtask

    task automatic end_session();
        @(negedge clk);
        load_en = 1'b0;
        repeat (8) @(negedge clk);
        check("byte_count", 32'(byte_count), 32'(exp_cnt));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("load_done", 32'(load_done), 32'(exp_cnt != 0));
        check("cpu_hold_end", 32'(cpu_hold), 32'd0);
    endtask

    task automatic drain_sb();
        vec_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            fetch_addr = e.addr;
            #1;
            check($sformatf("mem[%0d]", e.addr), 32'(fetch_data), 32'(e.data));
        end
    endtask

    task automatic peek(input string name, input logic [4:0] a,
                        input logic [7:0] d);
        fetch_addr = a;
        #1;
        check(name, 32'(fetch_data), 32'(d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    vec_t prog[6];

    initial begin
        prog[0] = '{5'd0, instr(OP_LDI, 5'd1)};
        prog[1] = '{5'd1, instr(OP_STA, 5'd29)};
        prog[2] = '{5'd2, instr(OP_LDI, 5'd0)};
        prog[3] = '{5'd3, instr(OP_STA, 5'd31)};
        prog[4] = '{5'd4, instr(OP_ADD, 5'd29)};
        prog[5] = '{5'd5, instr(OP_JMP, 5'd3)};

        repeat (3) @(negedge clk);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(byte_count), 32'd0);
        peek("rst_mem0", 5'd0, 8'h00);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // ser_clk activity with no session
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check("idle_count", 32'(byte_count), 32'd0);
        check("idle_hold", 32'(cpu_hold), 32'd0);
        peek("idle_mem0", 5'd0, 8'h00);

        // three full bytes
        start_session();
        send_byte(8'h21);
        send_byte(8'h7D);
        send_byte(8'hBF);
        end_session();
        drain_sb();
        peek("fetch1", 5'd1, 8'h7D);

        // partial second byte discarded
        do_reset();
        start_session();
        send_byte(8'h55);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        end_session();
        drain_sb();
        peek("partial_mem1", 5'd1, 8'h00);

        // 33 bytes: last one overflows
        do_reset();
        start_session();
        for (int i = 0; i < 33; i++) send_byte(8'(i + 1));
        end_session();
        drain_sb();
        peek("ovf_mem31", 5'd31, 8'h20);
        peek("ovf_mem0", 5'd0, 8'h01);

        // reset mid-load, load_en kept high
        do_reset();
        start_session();
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("mrst_hold", 32'(cpu_hold), 32'd0);
        check("mrst_count", 32'(byte_count), 32'd0);
        check("mrst_done", 32'(load_done), 32'd0);
        peek("mrst_mem0", 5'd0, 8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_cnt = 0;
        exp_ovf = 1'b0;
        repeat (6) @(negedge clk);
        check("mrst_rearm", 32'(cpu_hold), 32'd1);
        send_byte(8'hA5);
        end_session();
        drain_sb();
        peek("mrst_mem1", 5'd1, 8'h00);

        // counter program from the table
        do_reset();
        start_session();
        for (int i = 0; i < 6; i++) send_byte(prog[i].data);
        end_session();
        sb.delete();
        for (int i = 0; i < 6; i++) peek("prog", prog[i].addr, prog[i].data);
        peek("prog_nop", 5'd6, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
